// File: rtl/rmii_rx_framer.sv
// rmii_rx_framer: RMII receive front end.
// Samples 2-bit RXD/CRS_DV at the 50 MHz reference clock, strips the preamble and SFD,
// and emits payload bytes with the 4-byte FCS held back in a delay line. It checks CRC-32,
// length and dibit alignment, then reports one status strobe per frame.
// Ports:
//   clk, rst            reference clock, synchronous active-high reset
//   rmii_rxd[1:0]       receive dibit, LSB-first within a byte
//   rmii_crsdv          carrier sense / data valid
//   out_data[7:0]       payload byte, qualified by out_valid
//   out_valid, out_sof  byte strobe; sof marks the first payload byte
//   out_done            end-of-frame strobe carrying out_ok/out_len/out_err
//   out_len[10:0]       payload bytes emitted (FCS excluded)
//   out_err[3:0]        {align, long, runt, crc}
module rmii_rx_framer #(
  parameter int unsigned MIN_FRAME_BYTES = 64,
  parameter int unsigned MAX_FRAME_BYTES = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  rmii_rxd,
  input  logic        rmii_crsdv,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_done,
  output logic        out_ok,
  output logic [10:0] out_len,
  output logic [3:0]  out_err
);

  localparam logic [10:0] MinLen   = 11'(MIN_FRAME_BYTES);
  localparam logic [10:0] MaxLen   = 11'(MAX_FRAME_BYTES);
  localparam logic [31:0] CrcPoly  = 32'hEDB88320;
  localparam logic [31:0] CrcMagic = 32'hDEBB20E3;

  typedef enum logic [2:0] {StIdle, StPre, StData, StDrop, StDone} state_e;

  state_e           state_q, state_d;
  logic [7:0]       shreg_q;
  logic [1:0]       dibit_cnt_q;
  logic [10:0]      byte_cnt_q;
  logic [10:0]      emit_cnt_q;
  logic [31:0]      crc_q;
  logic [3:0][7:0]  dly_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             sof_q;

  logic [7:0]       new_byte;
  logic             byte_done;
  logic             frame_start;
  logic [3:0]       err;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CrcPoly) : (r >> 1);
    end
    return r;
  endfunction

  assign new_byte    = {rmii_rxd, shreg_q[7:2]};
  assign byte_done   = (state_q == StData) && rmii_crsdv && (dibit_cnt_q == 2'd3);
  assign frame_start = (state_q == StPre) && rmii_crsdv && (rmii_rxd == 2'b11);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (rmii_crsdv) state_d = (rmii_rxd == 2'b01) ? StPre : StDrop;
      StPre: begin
        if (!rmii_crsdv)             state_d = StIdle;
        else if (rmii_rxd == 2'b11)  state_d = StData;
        else if (rmii_rxd != 2'b01)  state_d = StDrop;
      end
      StData: if (!rmii_crsdv) state_d = StDone;
      StDrop: if (!rmii_crsdv) state_d = StIdle;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath: shift register, delay line, CRC and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q     <= '0;
      dibit_cnt_q <= '0;
      byte_cnt_q  <= '0;
      emit_cnt_q  <= '0;
      crc_q       <= '1;
      dly_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      if (frame_start) begin
        dibit_cnt_q <= '0;
        byte_cnt_q  <= '0;
        emit_cnt_q  <= '0;
        crc_q       <= '1;
      end else if (state_q == StData && rmii_crsdv) begin
        shreg_q     <= new_byte;
        dibit_cnt_q <= dibit_cnt_q + 2'd1;
        if (byte_done) begin
          dly_q <= {dly_q[2:0], new_byte};
          crc_q <= crc_byte(crc_q, new_byte);
          if (byte_cnt_q != 11'h7FF) byte_cnt_q <= byte_cnt_q + 11'd1;
          // Byte N = byte_cnt-4 leaves the delay line; cap emission at MAX-4 payload bytes.
          if (byte_cnt_q >= 11'd4 && byte_cnt_q < MaxLen) begin
            data_q     <= dly_q[3];
            valid_q    <= 1'b1;
            sof_q      <= (byte_cnt_q == 11'd4);
            emit_cnt_q <= emit_cnt_q + 11'd1;
          end
        end
      end
    end
  end

  // Output logic
  always_comb begin
    err[0]    = (crc_q != CrcMagic) || (byte_cnt_q < 11'd4);
    err[1]    = byte_cnt_q < MinLen;
    err[2]    = byte_cnt_q > MaxLen;
    err[3]    = dibit_cnt_q != 2'd0;
    out_done  = (state_q == StDone);
    out_err   = out_done ? err : 4'b0;
    out_ok    = out_done && (err == 4'b0);
    out_len   = out_done ? emit_cnt_q : 11'd0;
    out_data  = data_q;
    out_valid = valid_q;
    out_sof   = sof_q;
  end

endmodule

// File: tb/tb_rmii_rx_framer.sv
module tb_rmii_rx_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rmii_rxd;
  logic        rmii_crsdv;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_sof;
  logic        out_done;
  logic        out_ok;
  logic [10:0] out_len;
  logic [3:0]  out_err;

  rmii_rx_framer #(
    .MIN_FRAME_BYTES(64),
    .MAX_FRAME_BYTES(1518)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rmii_rxd  (rmii_rxd),
    .rmii_crsdv(rmii_crsdv),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .out_done  (out_done),
    .out_ok    (out_ok),
    .out_len   (out_len),
    .out_err   (out_err)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Monitor state (written only by the monitor process)
  logic [7:0] rx_q[$];
  int         sof_q[$];
  int         done_cnt = 0;
  logic       done_ok;
  logic [10:0] done_len;
  logic [3:0] done_err;

  // Transmit frame (payload + optional FCS), written only by the main process
  logic [7:0] tx[$];

  always @(negedge clk) begin
    if (out_valid) begin
      if (out_sof) sof_q.push_back(rx_q.size());
      rx_q.push_back(out_data);
    end
    if (out_done) begin
      done_cnt++;
      done_ok  = out_ok;
      done_len = out_len;
      done_err = out_err;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic send_dibit(input logic [1:0] d);
    @(negedge clk);
    rmii_crsdv = 1'b1;
    rmii_rxd   = d;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 4; i++) send_dibit(b[2*i +: 2]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rmii_crsdv = 1'b0;
      rmii_rxd   = 2'b00;
    end
  endtask

  // Payload 0..n-1 (low byte of index); optionally append FCS with bit 0 flipped on request.
  task automatic build(input int n, input bit fcs, input bit flip);
    logic [31:0] c;
    tx.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      tx.push_back(i[7:0]);
      c = crc_upd(c, i[7:0]);
    end
    if (fcs) begin
      c = ~c;
      if (flip) c[0] = ~c[0];
      for (int i = 0; i < 4; i++) tx.push_back(c[8*i +: 8]);
    end
  endtask

  task automatic send_frame(input int extra);
    for (int i = 0; i < 7; i++) send_byte(8'h55);
    send_byte(8'hD5);
    foreach (tx[i]) send_byte(tx[i]);
    for (int i = 0; i < extra; i++) send_dibit(2'b10);
    idle(1);
    repeat (6) @(negedge clk);
    #1;
  endtask

  // Compare n emitted bytes from index mark against tx[0..n-1].
  task automatic check_bytes(input string tag, input int mark, input int n);
    int errs = 0;
    chk({tag, "_count"}, rx_q.size() - mark, n);
    for (int i = 0; i < n && mark + i < rx_q.size(); i++)
      if (rx_q[mark + i] !== tx[i]) errs++;
    chk({tag, "_bytes"}, errs, 0);
  endtask

  task automatic check_sof(input string tag, input int smark, input int mark);
    chk({tag, "_sof_n"}, sof_q.size() - smark, 1);
    if (sof_q.size() > smark) chk({tag, "_sof_pos"}, sof_q[smark], mark);
  endtask

  task automatic good_frame(input string tag);
    int mark, smark, dmark;
    build(60, 1'b1, 1'b0);
    mark = rx_q.size(); smark = sof_q.size(); dmark = done_cnt;
    send_frame(0);
    check_bytes(tag, mark, 60);
    check_sof(tag, smark, mark);
    chk({tag, "_done"}, done_cnt - dmark, 1);
    chk({tag, "_ok"}, done_ok, 1);
    chk({tag, "_len"}, done_len, 60);
    chk({tag, "_err"}, done_err, 4'b0000);
  endtask

  initial begin
    int mark, smark, dmark;
    rst = 1'b1; rmii_crsdv = 1'b0; rmii_rxd = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_done", out_done, 0);
    chk("rst_data", out_data, 0);
    chk("rst_len", out_len, 0);
    chk("rst_err", out_err, 0);
    chk("rst_ok", out_ok, 0);
    rst = 1'b0;
    idle(2);

    // 1: good 60-byte frame
    good_frame("t1");

    // 2: FCS bit 0 flipped
    build(60, 1'b1, 1'b1);
    mark = rx_q.size(); dmark = done_cnt;
    send_frame(0);
    check_bytes("t2", mark, 60);
    chk("t2_done", done_cnt - dmark, 1);
    chk("t2_ok", done_ok, 0);
    chk("t2_err", done_err, 4'b0001);

    // 3: runt, 20 bytes + good FCS
    build(20, 1'b1, 1'b0);
    mark = rx_q.size(); dmark = done_cnt;
    send_frame(0);
    check_bytes("t3", mark, 20);
    chk("t3_ok", done_ok, 0);
    chk("t3_len", done_len, 20);
    chk("t3_err", done_err, 4'b0010);

    // 4: dribble dibit after a good frame
    build(60, 1'b1, 1'b0);
    mark = rx_q.size(); dmark = done_cnt;
    send_frame(1);
    check_bytes("t4", mark, 60);
    chk("t4_done", done_cnt - dmark, 1);
    chk("t4_ok", done_ok, 0);
    chk("t4_len", done_len, 60);
    chk("t4_err_hi", done_err[3:1], 3'b100);

    // 5: 1600-byte frame without FCS
    build(1600, 1'b0, 1'b0);
    mark = rx_q.size(); dmark = done_cnt;
    send_frame(0);
    check_bytes("t5", mark, 1514);
    chk("t5_done", done_cnt - dmark, 1);
    chk("t5_ok", done_ok, 0);
    chk("t5_len", done_len, 1514);
    chk("t5_long", done_err[2], 1);
    chk("t5_runt", done_err[1], 0);

    // 6: reset during frame A (before any byte can leave the delay line), then good frame B
    mark = rx_q.size(); dmark = done_cnt;
    for (int i = 0; i < 7; i++) send_byte(8'h55);
    send_byte(8'hD5);
    for (int i = 0; i < 3; i++) send_byte(8'hA0 + 8'(i));
    @(negedge clk);
    rst = 1'b1; rmii_crsdv = 1'b0; rmii_rxd = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(6);
    #1;
    chk("t6_a_bytes", rx_q.size() - mark, 0);
    chk("t6_a_done", done_cnt - dmark, 0);
    good_frame("t6b");

    // 7: carrier with a non-preamble dibit is ignored
    mark = rx_q.size(); dmark = done_cnt;
    for (int i = 0; i < 100; i++) send_dibit(2'b10);
    idle(6);
    #1;
    chk("t7_bytes", rx_q.size() - mark, 0);
    chk("t7_done", done_cnt - dmark, 0);
    good_frame("t7b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
